// File: rtl/pwm_pkg.sv
// Shared types and defaults for the PWM H-bridge motor driver.
// Drive-state encoding plus default counter width and dead-time length.
package pwm_pkg;

    typedef enum logic [1:0] {
        COAST,
        FWD,
        REV,
        BRAKE
    } drive_state_t;

    localparam int CNT_W_DEF    = 8;
    localparam int DEADTIME_DEF = 4;

endpackage

// File: rtl/pwm_motor_main_if.sv
// Control/drive bundle between register logic and the motor PWM block.
// master = control side, slave = PWM generator.
interface pwm_motor_main_if
    import pwm_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);

    logic             pwm_out;
    logic             direction;
    logic             motorbrake;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] duty_cycle;
    logic             motor_direction1;
    logic             motor_direction2;

    modport master (
        output pwm_out,
        output direction,
        output motorbrake,
        output period,
        output duty_cycle,
        input  motor_direction1,
        input  motor_direction2
    );

    modport slave (
        input  pwm_out,
        input  direction,
        input  motorbrake,
        input  period,
        input  duty_cycle,
        output motor_direction1,
        output motor_direction2
    );

endinterface

// File: rtl/pwm_counter.sv
// Free-running PWM counter with shadowed period/duty.
// Settings are adopted only at a period wrap, so duty edits are glitch-free.
module pwm_counter
    import pwm_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] duty_cycle,
    output logic             pwm_raw
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] per_q, per_d;
    logic [CNT_W-1:0] duty_q, duty_d;
    logic             per_zero;
    logic             wrap;

    // Period boundary detection; a zero period parks the counter at 0
    // and keeps sampling new settings every cycle.
    always_comb begin
        per_zero = (per_q == '0);
        wrap     = !per_zero && (cnt_q == per_q - CNT_W'(1));
        pwm_raw  = !per_zero && (cnt_q < duty_q);
    end

    // Next counter value and shadow reload at the wrap.
    always_comb begin
        cnt_d  = cnt_q + CNT_W'(1);
        per_d  = per_q;
        duty_d = duty_q;
        if (wrap || per_zero) begin
            cnt_d  = '0;
            per_d  = period;
            duty_d = duty_cycle;
        end
    end

    // Counter and shadow registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            per_q  <= '0;
            duty_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            per_q  <= per_d;
            duty_q <= duty_d;
        end
    end

endmodule

// File: rtl/pwm_motor_main.sv
// H-bridge leg driver: drive-state decode and registered leg outputs.
// Define PWM_DEADTIME_EN to blank both legs on a direction reversal.
module pwm_motor_main
    import pwm_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
`ifdef PWM_DEADTIME_EN
    ,
    parameter int DEADTIME = DEADTIME_DEF
`endif
) (
    input  logic              clk,
    input  logic              rst,
    pwm_motor_main_if.slave   bus
);

    drive_state_t state;
    logic         pwm_raw;
    logic         dt_hold;
    logic         md1_q, md1_d;
    logic         md2_q, md2_d;

    pwm_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk        (clk),
        .rst        (rst),
        .period     (bus.period),
        .duty_cycle (bus.duty_cycle),
        .pwm_raw    (pwm_raw)
    );

    // Drive-state priority: brake, then coast, then direction.
    always_comb begin
        state = REV;
        if (bus.motorbrake) begin
            state = BRAKE;
        end else if (!bus.pwm_out) begin
            state = COAST;
        end else if (bus.direction) begin
            state = FWD;
        end
    end

`ifdef PWM_DEADTIME_EN
    localparam int DT_W = $clog2(DEADTIME + 1);

    logic [DT_W-1:0] dt_q, dt_d;
    logic            dir_q, dir_d;

    // Dead-time window: a reversal while driving blanks both legs;
    // a further reversal inside the window restarts it.
    always_comb begin
        dir_d   = bus.direction;
        dt_d    = dt_q;
        dt_hold = 1'b0;
        if (dt_q != '0) begin
            dt_d    = dt_q - DT_W'(1);
            dt_hold = 1'b1;
        end
        if ((state == FWD || state == REV) && (bus.direction != dir_q)) begin
            dt_d    = DT_W'(DEADTIME - 1);
            dt_hold = 1'b1;
        end
    end

    // Dead-time counter and last-seen direction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dt_q  <= '0;
            dir_q <= 1'b0;
        end else begin
            dt_q  <= dt_d;
            dir_q <= dir_d;
        end
    end
`else
    assign dt_hold = 1'b0;
`endif

    // Leg drive per state; only brake ever raises both legs.
    always_comb begin
        md1_d = 1'b0;
        md2_d = 1'b0;
        unique case (state)
            BRAKE: begin
                md1_d = 1'b1;
                md2_d = 1'b1;
            end
            FWD:   md1_d = pwm_raw && !dt_hold;
            REV:   md2_d = pwm_raw && !dt_hold;
            COAST: ;
        endcase
    end

    // Registered leg outputs, cleared asynchronously on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            md1_q <= 1'b0;
            md2_q <= 1'b0;
        end else begin
            md1_q <= md1_d;
            md2_q <= md2_d;
        end
    end

    assign bus.motor_direction1 = md1_q;
    assign bus.motor_direction2 = md2_q;

endmodule

// File: tb/tb_pwm_motor_main.sv
// Testbench for pwm_motor_main (default build, no dead-time).
// Directed and random steps checked against a period-level reference model.
module tb_pwm_motor_main;

    logic clk;
    logic rst;

    pwm_motor_main_if #(.CNT_W(8)) bus ();

    pwm_motor_main #(
        .CNT_W (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: position inside the current period and the
    // settings that govern that period.
    int m_pos  = 0;
    int m_per  = 0;
    int m_duty = 0;

    logic [1:0] last_out;

    task automatic chk(input string tag, input logic [1:0] obs,
                       input logic [1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pos  = 0;
        m_per  = 0;
        m_duty = 0;
    endtask

    // One clock: predict outputs from current inputs, advance the model,
    // then sample 1 ns after the edge. Returns at the next falling edge.
    task automatic tick(input string tag);
        bit         high;
        logic [1:0] e;
        high = (m_per != 0) && (m_pos < m_duty);
        if (bus.motorbrake)     e = 2'b11;
        else if (!bus.pwm_out)  e = 2'b00;
        else if (bus.direction) e = {high, 1'b0};
        else                    e = {1'b0, high};
        if (m_per == 0 || m_pos + 1 >= m_per) begin
            m_per  = int'(bus.period);
            m_duty = int'(bus.duty_cycle);
            m_pos  = 0;
        end else begin
            m_pos++;
        end
        @(posedge clk);
        #1;
        last_out = {bus.motor_direction1, bus.motor_direction2};
        chk(tag, last_out, e);
        @(negedge clk);
    endtask

    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    // Count high cycles on each leg over one n-cycle window.
    task automatic count_highs(input string tag, input int n,
                               input int exp1, input int exp2);
        int h1;
        int h2;
        h1 = 0;
        h2 = 0;
        for (int i = 0; i < n; i++) begin
            tick(tag);
            h1 += int'(last_out[1]);
            h2 += int'(last_out[0]);
        end
        chk_int({tag, "_leg1_count"}, h1, exp1);
        chk_int({tag, "_leg2_count"}, h2, exp2);
    endtask

    task automatic set_io(input bit pwm, input bit dir, input bit brk,
                          input int per, input int duty);
        bus.pwm_out    = pwm;
        bus.direction  = dir;
        bus.motorbrake = brk;
        bus.period     = 8'(per);
        bus.duty_cycle = 8'(duty);
    endtask

    initial begin
        int  per;
        bit  seen;
        rst = 1'b1;
        set_io(1'b0, 1'b0, 1'b0, 0, 0);
        repeat (3) @(negedge clk);
        chk("reset_state", {bus.motor_direction1, bus.motor_direction2}, 2'b00);
        rst = 1'b0;
        model_reset();

        // Forward, 5/8.
        set_io(1'b1, 1'b1, 1'b0, 8, 5);
        run("fwd_settle", 12);
        count_highs("fwd_5of8", 8, 5, 0);
        run("fwd", 8);

        // Reverse, 5/8.
        bus.direction = 1'b0;
        run("rev_switch", 8);
        count_highs("rev_5of8", 8, 0, 5);

        // Coast and resume in phase.
        bus.pwm_out = 1'b0;
        count_highs("coast", 11, 0, 0);
        bus.pwm_out = 1'b1;
        run("resume", 16);

        // Brake in every pwm_out/direction combination, then release.
        for (int k = 0; k < 4; k++) begin
            bus.pwm_out    = k[0];
            bus.direction  = k[1];
            bus.motorbrake = 1'b1;
            count_highs("brake", 5, 5, 5);
            bus.motorbrake = 1'b0;
            run("brake_release", 6);
        end

        // Boundaries.
        set_io(1'b1, 1'b1, 1'b0, 8, 8);
        run("full_settle", 10);
        count_highs("duty_full", 8, 8, 0);
        bus.duty_cycle = 8'd0;
        run("zero_settle", 10);
        count_highs("duty_zero", 8, 0, 0);
        set_io(1'b1, 1'b0, 1'b0, 0, 5);
        run("per_zero_settle", 10);
        count_highs("period_zero", 8, 0, 0);

        // Mid-period duty change only lands after the wrap.
        set_io(1'b1, 1'b1, 1'b0, 8, 6);
        run("mid_settle", 11);
        bus.duty_cycle = 8'd2;
        run("mid_change", 16);

        // Randomized segments.
        for (int s = 0; s < 40; s++) begin
            per = int'($urandom_range(0, 20));
            set_io(1'($urandom), 1'($urandom), ($urandom_range(0, 5) == 0),
                   per, int'($urandom_range(0, per + 2)));
            run("random", int'($urandom_range(1, 25)));
        end

        // Asynchronous reset while leg 1 is high.
        set_io(1'b1, 1'b1, 1'b0, 8, 5);
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            tick("pre_reset");
            seen = last_out[1];
        end
        chk_int("pre_reset_high_seen", int'(seen), 1);
        #3;
        rst = 1'b1;
        #1;
        chk("async_reset", {bus.motor_direction1, bus.motor_direction2}, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        run("post_reset", 24);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
